// File: rtl/steer_cmd_sequencer_pkg.sv
// Shared types and defaults for the steering command sequencer.
package steer_pkg;

  localparam int X_W          = 11;
  localparam int CENTER_DEF   = 512;
  localparam int X_MAX_DEF    = 1023;
  localparam int STEP_DEF     = 8;
  localparam int TIMEOUT_DEF  = 100;
  localparam int DEADBAND_DEF = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    HOLD     = 2'd2,
    FAILSAFE = 2'd3
  } state_t;

endpackage

// File: rtl/steer_cmd_sequencer_if.sv
// Sample/period strobes in, slewed steering command and status out.
interface steer_cmd_sequencer_if;
  import steer_pkg::*;

  logic           sample_valid;
  logic [X_W-1:0] x_raw;
  logic           period_start;
  logic [X_W-1:0] x_val;
  logic           at_target;
  logic           failsafe;

  modport master (
    output sample_valid, x_raw, period_start,
    input  x_val, at_target, failsafe
  );

  modport slave (
    input  sample_valid, x_raw, period_start,
    output x_val, at_target, failsafe
  );
endinterface

// File: rtl/steer_cmd_sequencer_timeout.sv
// Counts PWM periods since the last joystick sample; pulses expired on the TIMEOUT-th.
module steer_timeout #(
  parameter int TIMEOUT = steer_pkg::TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic period_start,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // A sample in the same cycle as a period tick wins: the count restarts at zero.
  assign expired = enable && period_start && !clear && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      cnt_q <= '0;
    end else if (period_start && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/steer_cmd_sequencer.sv
// Steering command sequencer: latches joystick targets and slews x_val once per PWM period.
// Optional neutral deadband on latched samples is enabled by defining STEER_DEADBAND_EN.
module steer_cmd_sequencer
  import steer_pkg::*;
#(
  parameter int CENTER   = CENTER_DEF,
  parameter int X_MAX    = X_MAX_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int DEADBAND = DEADBAND_DEF
) (
  input logic                  clk,
  input logic                  rst,
  steer_cmd_sequencer_if.slave bus
);
  localparam logic [X_W-1:0]        CENTER_C = X_W'(CENTER);
  localparam logic [X_W-1:0]        X_MAX_C  = X_W'(X_MAX);
  localparam logic [X_W-1:0]        STEP_U   = X_W'(STEP);
  localparam logic signed [X_W:0]   STEP_S   = (X_W+1)'(STEP);
`ifdef STEER_DEADBAND_EN
  localparam logic signed [X_W:0]   DB_S     = (X_W+1)'(DEADBAND);
`endif

  function automatic logic [X_W-1:0] clamp_target(input logic [X_W-1:0] raw);
    logic [X_W-1:0] t;
`ifdef STEER_DEADBAND_EN
    logic signed [X_W:0] d;
    d = $signed({1'b0, raw}) - $signed({1'b0, CENTER_C});
`endif
    t = (raw > X_MAX_C) ? X_MAX_C : raw;
`ifdef STEER_DEADBAND_EN
    if ((d <= DB_S) && (d >= -DB_S)) t = CENTER_C;
`endif
    return t;
  endfunction

  // Result always lies between cur and tgt, so it can neither overshoot nor wrap.
  function automatic logic [X_W-1:0] slew(input logic [X_W-1:0] cur,
                                          input logic [X_W-1:0] tgt);
    logic signed [X_W:0] d;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (d > STEP_S)       return cur + STEP_U;
    else if (d < -STEP_S) return cur - STEP_U;
    else                  return tgt;
  endfunction

  state_t         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [X_W-1:0] target_q, target_d;
  logic           at_q, at_d;
  logic [X_W-1:0] new_tgt, stepped;
  logic           cnt_en, expired;

  assign cnt_en = (state_q == TRACK) || (state_q == HOLD);

  steer_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk          (clk),
    .rst          (rst),
    .period_start (bus.period_start),
    .clear        (bus.sample_valid),
    .enable       (cnt_en),
    .expired      (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= CENTER_C;
      target_q <= CENTER_C;
      at_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      target_q <= target_d;
      at_q     <= at_d;
    end
  end

  // A period tick steps toward the previously latched target, even if a sample lands in the same cycle.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    target_d = target_q;
    new_tgt  = bus.sample_valid ? clamp_target(bus.x_raw) : target_q;
    stepped  = bus.period_start ? slew(x_q, target_q) : x_q;

    unique case (state_q)
      IDLE: begin
        x_d = CENTER_C;
        if (bus.sample_valid) begin
          state_d  = TRACK;
          target_d = new_tgt;
        end
      end
      TRACK: begin
        x_d      = stepped;
        target_d = new_tgt;
        if (bus.period_start && (stepped == new_tgt)) state_d = HOLD;
      end
      HOLD: begin
        x_d      = stepped;
        target_d = new_tgt;
        if (bus.sample_valid && (new_tgt != x_q)) state_d = TRACK;
      end
      FAILSAFE: begin
        x_d      = stepped;
        target_d = new_tgt;
        if (bus.sample_valid) state_d = TRACK;
      end
      default: state_d = IDLE;
    endcase

    if (expired) begin
      state_d  = FAILSAFE;
      target_d = CENTER_C;
    end

    at_d = (x_d == target_d);
  end

  assign bus.x_val     = x_q;
  assign bus.at_target = at_q;
  assign bus.failsafe  = (state_q == FAILSAFE);
endmodule

// File: tb/tb_steer_cmd_sequencer.sv
// Directed bench for steer_cmd_sequencer with a queue-based scoreboard and negedge monitor.
module tb_steer_cmd_sequencer;
  logic clk = 1'b0;
  logic rst;

  steer_cmd_sequencer_if bus();

  steer_cmd_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] x;
    logic        at;
    logic        fs;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Each driven cycle leaves one expectation; the monitor checks it at the next falling edge.
  task automatic cyc(input logic r, input logic sv, input logic [10:0] xr, input logic ps,
                     input logic [10:0] ex, input logic ea, input logic ef, input string nm);
    exp_t e;
    @(negedge clk);
    rst              = r;
    bus.sample_valid = sv;
    bus.x_raw        = xr;
    bus.period_start = ps;
    @(posedge clk);
    #1;
    rst              = 1'b0;
    bus.sample_valid = 1'b0;
    bus.period_start = 1'b0;
    e.x  = ex;
    e.at = ea;
    e.fs = ef;
    e.nm = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if ((bus.x_val !== e.x) || (bus.at_target !== e.at) || (bus.failsafe !== e.fs)) begin
        n_bad++;
        $display("FAIL %s: got x_val=%0d at_target=%b failsafe=%b, want x_val=%0d at_target=%b failsafe=%b",
                 e.nm, bus.x_val, bus.at_target, bus.failsafe, e.x, e.at, e.fs);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int ex;
    rst              = 1'b1;
    bus.sample_valid = 1'b0;
    bus.x_raw        = '0;
    bus.period_start = 1'b0;

    // Reset, with inputs active during reset being ignored
    cyc(1, 1, 11'd900, 1, 11'd512, 1, 0, "reset_ignores_inputs");
    cyc(1, 0, 11'd0,   0, 11'd512, 1, 0, "reset_state");

    // Ramp 512 -> 700 in steps of 8, last step 696 -> 700
    cyc(0, 1, 11'd700, 0, 11'd512, 0, 0, "sample_700");
    for (int k = 1; k <= 24; k++) begin
      ex = (512 + 8*k > 700) ? 700 : 512 + 8*k;
      cyc(0, 0, 11'd0, 1, 11'(ex), (k == 24), 0, "ramp_700");
    end
    cyc(0, 0, 11'd0, 1, 11'd700, 1, 0, "hold_700");

    // Oversized sample clamps to 1023; no movement without a period tick
    cyc(0, 1, 11'd1500, 0, 11'd700, 0, 0, "clamp_sample");
    cyc(0, 0, 11'd0,    0, 11'd700, 0, 0, "no_change_mid_period");
    for (int k = 1; k <= 41; k++) begin
      ex = (700 + 8*k > 1023) ? 1023 : 700 + 8*k;
      cyc(0, 0, 11'd0, 1, 11'(ex), (k == 41), 0, "ramp_to_xmax");
    end
    cyc(0, 0, 11'd0, 1, 11'd1023, 1, 0, "xmax_no_wrap");

    // Reset in the middle of a ramp
    cyc(1, 0, 11'd0,   0, 11'd512, 1, 0, "reset_again");
    cyc(0, 1, 11'd600, 0, 11'd512, 0, 0, "sample_600");
    for (int k = 1; k <= 6; k++)
      cyc(0, 0, 11'd0, 1, 11'(512 + 8*k), 0, 0, "ramp_to_560");
    cyc(1, 0, 11'd0, 1, 11'd512, 1, 0, "reset_midramp");
    cyc(0, 0, 11'd0, 1, 11'd512, 1, 0, "idle_period_no_move");

    // Ramp down to 4, then to 0 with no underflow
    cyc(0, 1, 11'd4, 0, 11'd512, 0, 0, "sample_4");
    for (int k = 1; k <= 64; k++) begin
      ex = (512 - 8*k < 4) ? 4 : 512 - 8*k;
      cyc(0, 0, 11'd0, 1, 11'(ex), (k == 64), 0, "ramp_to_4");
    end
    cyc(0, 1, 11'd0, 0, 11'd4, 0, 0, "sample_0");
    cyc(0, 0, 11'd0, 1, 11'd0, 1, 0, "step_to_0");
    cyc(0, 0, 11'd0, 1, 11'd0, 1, 0, "floor_no_wrap");

    // Sample timeout: failsafe on the 100th tick, then ramp back to center
    cyc(1, 0, 11'd0,   0, 11'd512, 1, 0, "reset_fs");
    cyc(0, 1, 11'd600, 0, 11'd512, 0, 0, "sample_600_fs");
    for (int k = 1; k <= 11; k++) begin
      ex = (512 + 8*k > 600) ? 600 : 512 + 8*k;
      cyc(0, 0, 11'd0, 1, 11'(ex), (k == 11), 0, "ramp_600");
    end
    cyc(0, 1, 11'd600, 0, 11'd600, 1, 0, "resample_equal");
    for (int k = 1; k <= 99; k++)
      cyc(0, 0, 11'd0, 1, 11'd600, 1, 0, "timeout_wait");
    cyc(0, 0, 11'd0, 1, 11'd600, 0, 1, "timeout_fire");
    for (int k = 1; k <= 11; k++) begin
      ex = (600 - 8*k < 512) ? 512 : 600 - 8*k;
      cyc(0, 0, 11'd0, 1, 11'(ex), (k == 11), 1, "failsafe_ramp");
    end
    cyc(0, 0, 11'd0,   1, 11'd512, 1, 1, "failsafe_hold");
    cyc(0, 1, 11'd700, 0, 11'd512, 0, 0, "failsafe_exit");

    // Sample and period tick together: step uses old target, counter restarts
    cyc(1, 0, 11'd0,   0, 11'd512, 1, 0, "reset_same");
    cyc(0, 1, 11'd600, 0, 11'd512, 0, 0, "sample_600_same");
    cyc(0, 0, 11'd0,   1, 11'd520, 0, 0, "step_520");
    cyc(0, 0, 11'd0,   1, 11'd528, 0, 0, "step_528");
    cyc(0, 1, 11'd300, 1, 11'd536, 0, 0, "same_cycle_old_target");
    for (int k = 1; k <= 99; k++) begin
      ex = (536 - 8*k < 300) ? 300 : 536 - 8*k;
      cyc(0, 0, 11'd0, 1, 11'(ex), (k >= 30), 0, "toward_new_target");
    end
    cyc(0, 0, 11'd0, 1, 11'd300, 0, 1, "timeout_after_clear");

    // Deadband around center
    cyc(1, 0, 11'd0, 0, 11'd512, 1, 0, "reset_db");
`ifdef STEER_DEADBAND_EN
    cyc(0, 1, 11'd525, 0, 11'd512, 1, 0, "db_sample_525");
    cyc(0, 0, 11'd0,   1, 11'd512, 1, 0, "db_step1");
    cyc(0, 0, 11'd0,   1, 11'd512, 1, 0, "db_step2");
    cyc(0, 1, 11'd529, 0, 11'd512, 0, 0, "db_sample_529");
    cyc(0, 0, 11'd0,   1, 11'd520, 0, 0, "db_step3");
    cyc(0, 0, 11'd0,   1, 11'd528, 0, 0, "db_step4");
    cyc(0, 0, 11'd0,   1, 11'd529, 1, 0, "db_step5");
`else
    cyc(0, 1, 11'd525, 0, 11'd512, 0, 0, "nodb_sample_525");
    cyc(0, 0, 11'd0,   1, 11'd520, 0, 0, "nodb_step1");
    cyc(0, 0, 11'd0,   1, 11'd525, 1, 0, "nodb_step2");
    cyc(0, 1, 11'd529, 0, 11'd525, 0, 0, "nodb_sample_529");
    cyc(0, 0, 11'd0,   1, 11'd529, 1, 0, "nodb_step3");
    cyc(0, 0, 11'd0,   1, 11'd529, 1, 0, "nodb_step4");
`endif

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
